// File: rtl/adt7420_pkg.sv
// Shared constants for the ADT7420 register-level I2C responder:
// default address, register map, FSM encoding and the read multiplexer.
package adt7420_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h4B;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_STATUS   = 8'h02;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  typedef logic [3:0] rsp_state_t;

  localparam rsp_state_t ST_IDLE      = 4'd0;
  localparam rsp_state_t ST_ADDR      = 4'd1;
  localparam rsp_state_t ST_ADDR_ACK  = 4'd2;
  localparam rsp_state_t ST_PTR       = 4'd3;
  localparam rsp_state_t ST_PTR_ACK   = 4'd4;
  localparam rsp_state_t ST_WDATA     = 4'd5;
  localparam rsp_state_t ST_WDATA_ACK = 4'd6;
  localparam rsp_state_t ST_TX        = 4'd7;
  localparam rsp_state_t ST_RX_ACK    = 4'd8;
  localparam rsp_state_t ST_WAIT_STOP = 4'd9;

  // Byte served for a given pointer; the temperature always comes from a snapshot.
  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [15:0] temp,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  id);
    case (ptr)
      REG_TEMP_MSB: reg_read = temp[15:8];
      REG_TEMP_LSB: reg_read = temp[7:0];
      REG_STATUS:   reg_read = 8'h00;
      REG_CONFIG:   reg_read = cfg;
      REG_ID:       reg_read = id;
      default:      reg_read = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/adt7420_responder_if.sv
// Register-side view of the responder: temperature in, config/pointer/status out.
interface adt7420_responder_if;

  logic [15:0] temp_value;
  logic [7:0]  config_reg;
  logic [7:0]  pointer;
  logic        busy;
  logic        addr_hit;
  logic [3:0]  rsp_state;

  modport slave  (input  temp_value,
                  output config_reg, pointer, busy, addr_hit, rsp_state);
  modport master (output temp_value,
                  input  config_reg, pointer, busy, addr_hit, rsp_state);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges
// plus START/STOP conditions as single-cycle pulses.
module i2c_line_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STG-1:0] scl_pipe;
  logic [SYNC_STG-1:0] sda_pipe;
  logic                scl_d;
  logic                sda_d;
  logic                scl;

  // NOTE: flops reset to 1 (idle bus level) so leaving reset never looks like START/STOP.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STG-2:0], scl_raw};
      sda_pipe <= {sda_pipe[SYNC_STG-2:0], sda_raw};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl       = scl_pipe[SYNC_STG-1];
  assign sda       = sda_pipe[SYNC_STG-1];
  assign scl_rise  =  scl & ~scl_d;
  assign scl_fall  = ~scl &  scl_d;
  assign start_det =  scl &  scl_d &  sda_d & ~sda;
  assign stop_det  =  scl &  scl_d & ~sda_d &  sda;

endmodule

// File: rtl/adt7420_responder.sv
// I2C target emulating the ADT7420 register interface: pointer write, config
// write, and auto-incrementing reads of a temperature snapshot, config and ID.
module adt7420_responder
  import adt7420_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter logic [7:0] ID_VALUE = 8'hCB,
  parameter int         SYNC_STG = 2
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic TMP_SCL,
  inout  wire  TMP_SDA,
  adt7420_responder_if.slave regs
);

  logic       sda, scl_rise, scl_fall, start_det, stop_det;
  rsp_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, tx_byte, pointer, config_reg;
  logic [15:0] snap;
  logic       rw, ack_phase, sda_oe, busy, addr_hit;
  logic [7:0] rx_next, ptr_inc, first_byte, next_byte;

  i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .scl_raw   (TMP_SCL),
    .sda_raw   (TMP_SDA),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_next    = {shreg[6:0], sda};
  assign ptr_inc    = pointer + 8'd1;
  // First read byte is taken from the live word, the same value being snapshotted.
  assign first_byte = reg_read(pointer, regs.temp_value, config_reg, ID_VALUE);
  assign next_byte  = reg_read(ptr_inc, snap, config_reg, ID_VALUE);

  assign TMP_SDA = sda_oe ? 1'b0 : 1'bz;

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      tx_byte    <= 8'h00;
      pointer    <= 8'h00;
      config_reg <= 8'h00;
      snap       <= 16'h0000;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      addr_hit   <= 1'b0;
    end else begin
      addr_hit <= 1'b0;
      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
            shreg   <= rx_next;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if (state == ST_ADDR) begin
                if (rx_next[7:1] == DEV_ADDR) begin
                  state    <= ST_ADDR_ACK;
                  rw       <= rx_next[0];
                  addr_hit <= 1'b1;
                  busy     <= 1'b1;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end else if (state == ST_PTR) begin
                pointer <= rx_next;
                state   <= ST_PTR_ACK;
              end else begin
                if (pointer == REG_CONFIG) config_reg <= rx_next;
                state <= ST_WDATA_ACK;
              end
            end
          end
          // First fall pulls the ACK low, second fall ends the ACK slot.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              if (state == ST_ADDR_ACK && rw) begin
                snap    <= regs.temp_value;
                sda_oe  <= ~first_byte[7];
                tx_byte <= {first_byte[6:0], 1'b0};
                bit_cnt <= 4'd1;
                state   <= ST_TX;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_TX: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= ST_RX_ACK;
            end else begin
              sda_oe  <= ~tx_byte[7];
              tx_byte <= {tx_byte[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RX_ACK: if (scl_rise) begin
            if (!sda) begin
              pointer <= ptr_inc;
              tx_byte <= next_byte;
              bit_cnt <= 4'd0;
              state   <= ST_TX;
            end else begin
              state <= ST_WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign regs.config_reg = config_reg;
  assign regs.pointer    = pointer;
  assign regs.busy       = busy;
  assign regs.addr_hit   = addr_hit;
  assign regs.rsp_state  = state;

endmodule

// File: tb/tb_adt7420_responder.sv
// Directed bench for adt7420_responder: a bit-level I2C initiator model with a
// read-data scoreboard and a monitor that SDA only moves while SCL is low.
module tb_adt7420_responder;
  import adt7420_pkg::*;

  localparam int Q = 20;  // quarter SCL period in system clocks

  logic CLK100MHZ;
  logic reset;
  logic scl;
  logic sda_low;
  logic cond;     // initiator is deliberately making START/STOP
  logic mon_en;
  wire  sda;
  int   checks;
  int   errors;
  int   hit_count;
  logic [7:0] exp_q[$];

  adt7420_responder_if regs ();

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  adt7420_responder dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .TMP_SCL   (scl),
    .TMP_SDA   (sda),
    .regs      (regs)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(sda) if (mon_en) check("sda_while_scl_high", {15'd0, (scl === 1'b0) || cond}, 16'd1);

  always @(negedge CLK100MHZ) if (!reset && regs.addr_hit === 1'b1) hit_count++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic i2c_start();
    scl = 1'b1; wait_clk(Q);
    cond = 1'b1; sda_low = 1'b1; wait_clk(Q);
    cond = 1'b0; scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    cond = 1'b1; sda_low = 1'b1; wait_clk(Q);
    cond = 1'b0; scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    cond = 1'b1; sda_low = 1'b0; wait_clk(Q);
    cond = 1'b0;
  endtask

  task automatic write_bit(input logic b);
    wait_clk(Q); sda_low = ~b; wait_clk(Q);
    scl = 1'b1; wait_clk(2 * Q);
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; wait_clk(2 * Q);
    scl = 1'b1; wait_clk(Q);
    b = sda; wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    acked = (a === 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic send_ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(~send_ack);
  endtask

  task automatic read_scored(input string tag, input logic send_ack);
    logic [7:0] d, e;
    read_byte(d, send_ack);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {8'd0, d}, {8'd0, e});
  endtask

  task automatic write_expect_ack(input string tag, input logic [7:0] d);
    logic a;
    write_byte(d, a);
    check(tag, {15'd0, a}, 16'd1);
  endtask

  initial begin
    logic       a, b;
    checks = 0; errors = 0; hit_count = 0;
    reset = 1'b1; scl = 1'b1; sda_low = 1'b0; cond = 1'b0; mon_en = 1'b0;
    regs.temp_value = 16'h0000;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    check("rst_state",   {12'd0, regs.rsp_state}, {12'd0, ST_IDLE});
    check("rst_pointer", {8'd0, regs.pointer}, 16'h0000);
    check("rst_config",  {8'd0, regs.config_reg}, 16'h0000);
    check("rst_busy",    {15'd0, regs.busy}, 16'd0);
    check("rst_sda",     {15'd0, sda}, 16'd1);
    mon_en = 1'b1;

    // 1: pointer write, repeated START, two-byte read
    regs.temp_value = 16'h0C80;
    i2c_start();
    write_expect_ack("t1_addr_w", 8'h96);
    check("t1_busy_on", {15'd0, regs.busy}, 16'd1);
    write_expect_ack("t1_ptr", 8'h00);
    check("t1_pointer", {8'd0, regs.pointer}, 16'h0000);
    i2c_rstart();
    write_expect_ack("t1_addr_r", 8'h97);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h80);
    read_scored("t1_msb", 1'b1);
    read_scored("t1_lsb", 1'b0);
    wait_clk(5);
    check("t1_wait_stop", {12'd0, regs.rsp_state}, {12'd0, ST_WAIT_STOP});
    check("t1_ptr_inc", {8'd0, regs.pointer}, 16'h0001);
    check("t1_busy_held", {15'd0, regs.busy}, 16'd1);
    i2c_stop();
    wait_clk(5);
    check("t1_busy_off", {15'd0, regs.busy}, 16'd0);
    check("t1_hits", hit_count[15:0], 16'd2);
    check("t1_idle", {12'd0, regs.rsp_state}, {12'd0, ST_IDLE});

    // 2: foreign address gets no ACK
    i2c_start();
    write_byte(8'h90, a);
    check("t2_no_ack", {15'd0, a}, 16'd0);
    wait_clk(5);
    check("t2_state", {12'd0, regs.rsp_state}, {12'd0, ST_WAIT_STOP});
    check("t2_pointer", {8'd0, regs.pointer}, 16'h0001);
    check("t2_hits", hit_count[15:0], 16'd2);
    i2c_stop();

    // 3: config write, then read it back
    i2c_start();
    write_expect_ack("t3_addr", 8'h96);
    write_expect_ack("t3_ptr", 8'h03);
    write_expect_ack("t3_data", 8'hA5);
    i2c_stop();
    wait_clk(5);
    check("t3_config", {8'd0, regs.config_reg}, 16'h00A5);
    check("t3_pointer", {8'd0, regs.pointer}, 16'h0003);
    i2c_start();
    write_expect_ack("t3_addr2", 8'h96);
    write_expect_ack("t3_ptr2", 8'h03);
    i2c_rstart();
    write_expect_ack("t3_addr_r", 8'h97);
    exp_q.push_back(8'hA5);
    read_scored("t3_cfg_rd", 1'b0);
    i2c_stop();

    // 4: pointer wraps 0xFF -> 0x00
    regs.temp_value = 16'h1234;
    i2c_start();
    write_expect_ack("t4_addr", 8'h96);
    write_expect_ack("t4_ptr", 8'hFF);
    i2c_rstart();
    write_expect_ack("t4_addr_r", 8'h97);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h12);
    read_scored("t4_ff", 1'b1);
    read_scored("t4_wrap_msb", 1'b0);
    check("t4_pointer", {8'd0, regs.pointer}, 16'h0000);
    i2c_stop();

    // 5: temperature changes between MSB and LSB reads
    regs.temp_value = 16'h5678;
    i2c_start();
    write_expect_ack("t5_addr", 8'h96);
    write_expect_ack("t5_ptr", 8'h00);
    i2c_rstart();
    write_expect_ack("t5_addr_r", 8'h97);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    read_scored("t5_msb", 1'b1);
    regs.temp_value = 16'hABCD;
    read_scored("t5_lsb_snap", 1'b0);
    i2c_stop();

    // 6: reset while the responder drives a 0 data bit
    regs.temp_value = 16'h00FF;
    i2c_start();
    write_expect_ack("t6_addr", 8'h96);
    write_expect_ack("t6_ptr", 8'h00);
    i2c_rstart();
    write_expect_ack("t6_addr_r", 8'h97);
    read_bit(b);
    check("t6_bit7", {15'd0, b}, 16'd0);
    read_bit(b);
    wait_clk(Q);
    check("t6_driving_0", {15'd0, sda}, 16'd0);
    #3 reset = 1'b1;
    #1 check("t6_sda_released", {15'd0, sda}, 16'd1);
    check("t6_state",   {12'd0, regs.rsp_state}, {12'd0, ST_IDLE});
    check("t6_pointer", {8'd0, regs.pointer}, 16'h0000);
    check("t6_config",  {8'd0, regs.config_reg}, 16'h0000);
    check("t6_busy",    {15'd0, regs.busy}, 16'd0);
    check("t6_addr_hit", {15'd0, regs.addr_hit}, 16'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    scl = 1'b1;
    wait_clk(Q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
